sevenseg_scan_driver: RTL and testbench
=======================================

# sevenseg_scan_driver

Time-multiplexed seven-segment display driver for a parametrised number of hex digits, with tear-free value loading, optional leading-zero blanking and per-digit blink. It takes a binary value from the calculator datapath (operand or result) and drives one shared active-low segment bus plus active-low digit enables. It replaces static per-digit decoding on boards with multiplexed displays.

## Interface
- NUM_DIGITS, 8: number of hex digits scanned (1..16); value width is 4*NUM_DIGITS
- SCAN_DIV, 50000: clock cycles each digit is enabled (≥2)
- BLINK_FRAMES, 64: scan frames per blink half-period (≥1; used only with blink compiled in)
- clk  in  1  system clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe: capture value into shadow register
- value  in  4*NUM_DIGITS  binary number to display
- lz_en  in  1  1 = blank leading zero digits (digit 0 never blanked)
- blink_mask  in  NUM_DIGITS  per-digit blink select (ignored when blink compiled out)
- pending  out  1  shadow holds a value not yet committed to display
- seg  out  7  active-low segments {g,f,e,d,c,b,a}; 7'b111_1111 = blank
- an  out  NUM_DIGITS  active-low digit enables, one-hot-low or all-ones

## Operation
- Registers: shadow (4*NUM_DIGITS), disp (4*NUM_DIGITS), prescaler (clog2 SCAN_DIV), digit index idx (clog2 NUM_DIGITS), pending.
- load=1: shadow <= value, pending <= 1. Repeated loads before commit: last one wins.
- Frame boundary = cycle where prescaler == SCAN_DIV-1 and idx == NUM_DIGITS-1. On it: if pending, disp <= shadow, pending <= 0. load on that same cycle: shadow and pending take the new value (pending stays 1), disp takes the old shadow.
- Prescaler counts 0..SCAN_DIV-1, wraps to 0; on wrap, idx advances, NUM_DIGITS-1 wraps to 0.
- Leading-zero mask: digit k (k≥1) blank when lz_en=1 and nibbles k..NUM_DIGITS-1 of disp are all zero. Digit 0 always shown; disp=0 displays "0".
- seg for shown digit = hex glyph of disp nibble idx (0-9, A, b, C, d, E, F); for blanked digit seg = 7'b111_1111 while an still asserts that digit.
- an: bit idx low, all others high.
- lz_en and blink_mask are sampled live each cycle (not shadowed).

## Timing
- Reset: seg = 7'h7F, an = all ones, pending = 0, shadow = disp = 0, prescaler = 0, idx = 0, blink phase = visible.
- First cycle after reset release: outputs still blank; seg/an registered, so they reflect idx/disp with 1-cycle latency. an goes to ~1 (digit 0) on cycle 1 after release.
- Each digit enabled exactly SCAN_DIV cycles; frame = NUM_DIGITS*SCAN_DIV cycles.
- pending rises the cycle after load; load-to-visible worst case NUM_DIGITS*SCAN_DIV+1 cycles, best case 2.
- Mid-frame loads never change displayed digits within the current frame (no tearing).
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous); pending load discarded.

## Configuration
- SEVENSEG_BLINK_EN defined: frame counter toggles blink phase every BLINK_FRAMES frames; in the hidden phase digits with blink_mask[k]=1 output seg = 7'h7F. Phase resets to visible.
- Undefined: no frame counter or phase register; blink_mask unconnected internally; BLINK_FRAMES unused.

## Structure
- Package sevenseg_pkg: SEG_BLANK = 7'b111_1111, 16-entry glyph constant table, function for clog2 of parameters with minimum 1.
- One sub-module: hex_to_seg7 (4-bit nibble in, 7-bit active-low glyph out, combinational), instantiated once on the selected nibble.
- Leading-zero mask: NUM_DIGITS-bit OR-chain from the top nibble downward, generated by a loop.

## Test plan
- NUM_DIGITS=4, SCAN_DIV=4: reset, load value=16'h1A3F -> per frame an cycles 1110,1101,1011,0111 for 4 cycles each, seg = glyphs F,3,A,1 (7'h0E,7'h30,7'h08,7'h79).
- lz_en=1, load 16'h0005 -> digit 0 shows 7'h12, digits 1-3 seg=7'h7F; load 16'h0000 -> digit 0 shows 7'h40, others blank.
- Load 16'h1111 at prescaler 1 of digit 1 -> digits 1-3 still show old value that frame; pending=1 until frame boundary, then 0 and all digits show 1 (7'h79).
- Two loads 16'h2222 then 16'h3333 in one frame -> only 3333 ever displayed; load on frame-boundary cycle -> old shadow commits, pending stays 1, new value commits next frame.
- Assert rst_n=0 mid-digit-2 with pending=1 -> seg=7'h7F, an=4'hF, pending=0 same cycle; after release display shows 0 on digit 0.
- With SEVENSEG_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0100 -> digit 2 blank during frames 2-3, 6-7, ...; other digits unaffected; without the macro digit 2 never blanks.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared constants for the multiplexed seven-segment driver.
// Active-low glyph table {g,f,e,d,c,b,a} and a parameter-width helper.
package sevenseg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b111_1111;

   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Bits needed to count 0..v-1, never less than one.
   function automatic int clog2_min1(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sevenseg_scan_driver_hex.sv
// hex_to_seg7: combinational nibble to active-low seven-segment glyph.
// Lookup into the shared glyph table.
module hex_to_seg7
   import sevenseg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   // Table lookup, one glyph per hex value.
   always_comb begin
      seg = GLYPH_TABLE[nib];
   end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed hex display with tear-free loads.
// Optional per-digit blink is compiled in with SEVENSEG_BLINK_EN.
module sevenseg_scan_driver
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    lz_en,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic                    pending,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an
);

   localparam int VW = 4 * NUM_DIGITS;
   localparam int PW = clog2_min1(SCAN_DIV);
   localparam int IW = clog2_min1(NUM_DIGITS);
   localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [VW-1:0]         shadow_q, shadow_d;
   logic [VW-1:0]         disp_q, disp_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  pending_q, pending_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;

   logic                  presc_wrap;
   logic                  frame_end;
   logic [NUM_DIGITS-1:0] upper_nz;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic [NUM_DIGITS-1:0] blink_hide;
   logic [NUM_DIGITS-1:0] digit_blank;
   logic [3:0]            cur_nib;
   logic                  cur_blank;
   logic [6:0]            cur_glyph;

   assign presc_wrap = (presc_q == PS_LAST);
   assign frame_end  = presc_wrap && (idx_q == IDX_LAST);

   // Digit 0 counts as significant so it is never blanked; each
   // higher digit is significant if it or anything above it is nonzero.
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
      if (k == 0) begin : g_low
         assign upper_nz[k] = 1'b1;
      end else if (k == NUM_DIGITS - 1) begin : g_top
         assign upper_nz[k] = |disp_q[4*k +: 4];
      end else begin : g_mid
         assign upper_nz[k] = upper_nz[k+1] | (|disp_q[4*k +: 4]);
      end
      assign lz_blank[k] = lz_en & ~upper_nz[k];
   end

`ifdef SEVENSEG_BLINK_EN
   localparam int FW = clog2_min1(BLINK_FRAMES);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic          hidden_q, hidden_d;

   // Count completed frames; flip blink phase every BLINK_FRAMES of them.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      hidden_d    = hidden_q;
      if (frame_end) begin
         if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            hidden_d    = ~hidden_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
         end
      end
   end

   // Blink phase registers, visible phase out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         hidden_q    <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         hidden_q    <= hidden_d;
      end
   end

   assign blink_hide = blink_mask & {NUM_DIGITS{hidden_q}};
`else
   logic [NUM_DIGITS-1:0] unused_blink_mask;
   localparam int unused_blink_frames = BLINK_FRAMES;

   assign unused_blink_mask = blink_mask;
   assign blink_hide        = '0;
`endif

   assign digit_blank = lz_blank | blink_hide;

   // Pick the nibble and blank flag of the digit currently scanned.
   always_comb begin
      cur_nib   = '0;
      cur_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            cur_nib   = disp_q[4*k +: 4];
            cur_blank = digit_blank[k];
         end
      end
   end

   hex_to_seg7 u_glyph (
      .nib (cur_nib),
      .seg (cur_glyph)
   );

   // Scan counters, shadow/commit handshake and next output pattern.
   always_comb begin
      presc_d   = presc_q + PW'(1);
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      disp_d    = disp_q;
      pending_d = pending_q;
      if (presc_wrap) begin
         presc_d = '0;
         idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
      // Commit only at frame end so a frame never mixes two values.
      if (frame_end && pending_q) begin
         disp_d    = shadow_q;
         pending_d = 1'b0;
      end
      if (load) begin
         shadow_d  = value;
         pending_d = 1'b1;
      end
      seg_d = cur_blank ? SEG_BLANK : cur_glyph;
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
   end

   // State and registered outputs; everything dark out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q  <= '0;
         disp_q    <= '0;
         presc_q   <= '0;
         idx_q     <= '0;
         pending_q <= 1'b0;
         seg_q     <= SEG_BLANK;
         an_q      <= '1;
      end else begin
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign pending = pending_q;
   assign seg     = seg_q;
   assign an      = an_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: directed scoreboard bench, 4 digits, 4-cycle scan.
// Expected an/seg/pending per cycle are queued per frame, then compared.
module tb_sevenseg_scan_driver;

   localparam int ND = 4;
   localparam int SD = 4;
   localparam int BF = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] value;
   logic        lz_en;
   logic [3:0]  blink_mask;
   logic        pending;
   logic [6:0]  seg;
   logic [3:0]  an;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       pend;
   } exp_t;

   exp_t sb[$];

   logic [15:0] m_shadow;
   logic [15:0] m_disp;
   logic        m_pend;
   int          m_frame;

   always #5 clk = ~clk;

   sevenseg_scan_driver #(
      .NUM_DIGITS   (ND),
      .SCAN_DIV     (SD),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .value      (value),
      .lz_en      (lz_en),
      .blink_mask (blink_mask),
      .pending    (pending),
      .seg        (seg),
      .an         (an)
   );

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [6:0] obs,
                      input logic [6:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset;
      m_shadow = '0;
      m_disp   = '0;
      m_pend   = 1'b0;
      m_frame  = 0;
   endtask

   // Runs nsteps cycles of the current frame with up to two loads.
   task automatic run_frame(input int nsteps,
                            input int la, input logic [15:0] va,
                            input int lb, input logic [15:0] vb);
      logic [15:0] sh;
      logic [15:0] nd;
      logic        pnd;
      logic        hid;
      logic        blank;
      exp_t        e;
      int          k;
      sh  = m_shadow;
      nd  = m_disp;
      pnd = m_pend;
      hid = 1'b0;
`ifdef SEVENSEG_BLINK_EN
      hid = ((m_frame / BF) % 2) == 1;
`endif
      for (int j = 0; j < nsteps; j++) begin
         k     = j / SD;
         blank = (k > 0) && lz_en && ((m_disp >> (4 * k)) == 16'h0);
         if (hid && blink_mask[k]) blank = 1'b1;
         e.an  = ~(4'b0001 << k);
         e.seg = blank ? 7'h7F : glyph(m_disp[4*k +: 4]);
         if (j == ND * SD - 1 && pnd) begin
            nd  = sh;
            pnd = 1'b0;
         end
         if (j == la) begin
            sh  = va;
            pnd = 1'b1;
         end
         if (j == lb) begin
            sh  = vb;
            pnd = 1'b1;
         end
         e.pend = pnd;
         sb.push_back(e);
      end
      for (int j = 0; j < nsteps; j++) begin
         load  = (j == la) || (j == lb);
         value = (j == lb) ? vb : ((j == la) ? va : 16'($urandom));
         step();
         load = 1'b0;
         e = sb.pop_front();
         chk($sformatf("an f%0d s%0d", m_frame, j), {3'b0, an}, {3'b0, e.an});
         chk($sformatf("seg f%0d s%0d", m_frame, j), seg, e.seg);
         chk($sformatf("pend f%0d s%0d", m_frame, j),
             {6'b0, pending}, {6'b0, e.pend});
      end
      m_shadow = sh;
      m_pend   = pnd;
      if (nsteps == ND * SD) begin
         m_disp = nd;
         m_frame++;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      load       = 1'b0;
      value      = 16'h0;
      lz_en      = 1'b0;
      blink_mask = 4'b0100;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst seg", seg, 7'h7F);
      chk("rst an", {3'b0, an}, 7'h0F);
      chk("rst pend", {6'b0, pending}, 7'h00);

      rst_n = 1'b1;
      chk("rel seg", seg, 7'h7F);
      chk("rel an", {3'b0, an}, 7'h0F);

      run_frame(16, 5, 16'h1A3F, -1, 16'h0);
      run_frame(16, -1, 16'h0, -1, 16'h0);
      lz_en = 1'b1;
      run_frame(16, 0, 16'h0005, -1, 16'h0);
      run_frame(16, 10, 16'h0000, -1, 16'h0);
      run_frame(16, 5, 16'h1111, -1, 16'h0);
      run_frame(16, -1, 16'h0, -1, 16'h0);
      run_frame(16, 2, 16'h2222, 9, 16'h3333);
      run_frame(16, 3, 16'h5555, 15, 16'h6666);
      run_frame(16, -1, 16'h0, -1, 16'h0);
      run_frame(16, -1, 16'h0, -1, 16'h0);
      run_frame(10, 2, 16'h7777, -1, 16'h0);
      chk("pre-rst pend", {6'b0, pending}, 7'h01);

      rst_n = 1'b0;
      #1;
      chk("async seg", seg, 7'h7F);
      chk("async an", {3'b0, an}, 7'h0F);
      chk("async pend", {6'b0, pending}, 7'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      chk("rel2 seg", seg, 7'h7F);

      run_frame(16, 7, 16'h8888, -1, 16'h0);
      run_frame(16, -1, 16'h0, -1, 16'h0);
      run_frame(16, -1, 16'h0, -1, 16'h0);
      run_frame(16, -1, 16'h0, -1, 16'h0);
      run_frame(16, -1, 16'h0, -1, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
